// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/LS memory port arbiter: FSM states, access owner,
// latched request record and the full-word byte-enable constant.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
  } mem_req_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // Memory is word addressed; byte lanes are selected by be, not addr[1:0].
  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// LS-priority grant with an anti-starvation streak for IF. Combinational grants,
// only while idle & ce; the streak register updates on the granting edge.
module mem_arb_prio
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic idle,
  input  logic if_vld,
  input  logic ls_vld,
  output logic if_gnt,
  output logic ls_gnt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] streak_q, streak_d;
  logic          starve;

  assign starve = (streak_q == SW'(STARVE_LIMIT));
  assign if_gnt = idle & ce & if_vld & (~ls_vld | starve);
  assign ls_gnt = idle & ce & ls_vld & ~(if_vld & starve);

  // Only contended LS wins count toward starving IF.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt) begin
      streak_d = '0;
    end else if (ls_gnt && if_vld && !starve) begin
      streak_d = streak_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and load/store (LS); accept to rsp_valid
// is MEM_LATENCY+1 cycles, one access in flight, requests accepted only when idle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        if_req_valid,
  output logic        if_req_ready,
  input  logic [31:0] if_addr,
  output logic        if_rsp_valid,
  output logic [31:0] if_rdata,
  input  logic        ls_req_valid,
  output logic        ls_req_ready,
  input  logic [31:0] ls_addr,
  input  logic        ls_we,
  input  logic [3:0]  ls_be,
  input  logic [31:0] ls_wdata,
  output logic        ls_rsp_valid,
  output logic [31:0] ls_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  mem_req_t         req_q, req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [31:0]      ls_rdata_q, ls_rdata_d;
  logic             idle, if_gnt, ls_gnt;

  // Gating idle with reset keeps both readies low while reset is held.
  assign idle = (state_q == IDLE) & reset;

  mem_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .idle  (idle),
    .if_vld(if_req_valid),
    .ls_vld(ls_req_valid),
    .if_gnt(if_gnt),
    .ls_gnt(ls_gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    case (state_q)
      IDLE: begin
        if (if_gnt) begin
          req_d.addr = word_addr(if_addr);
          req_d.we   = 1'b0;
          req_d.be   = BE_WORD;
          owner_d    = OWN_IF;
          cnt_d      = CNT_W'(MEM_LATENCY);
          state_d    = BUSY;
        end else if (ls_gnt) begin
          req_d.addr  = word_addr(ls_addr);
          req_d.we    = ls_we;
          req_d.be    = ls_be;
          req_d.wdata = ls_wdata;
          owner_d     = OWN_LS;
          cnt_d       = CNT_W'(MEM_LATENCY);
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (ce) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (owner_q == OWN_IF) begin
              if_rdata_d = mem_rdata;
            end else if (!req_q.we) begin
              ls_rdata_d = mem_rdata;
            end
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (ce) begin
          owner_d = OWN_NONE;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      req_q      <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  assign if_req_ready = if_gnt;
  assign ls_req_ready = ls_gnt;
  assign if_rsp_valid = (state_q == RESP) & ce & (owner_q == OWN_IF);
  assign ls_rsp_valid = (state_q == RESP) & ce & (owner_q == OWN_LS);
  assign if_rdata     = if_rdata_q;
  assign ls_rdata     = ls_rdata_q;

  // The counter still holds MEM_LATENCY only in the first BUSY cycle.
  assign mem_addr  = req_q.addr;
  assign mem_be    = req_q.be;
  assign mem_wdata = req_q.wdata;
  assign mem_we    = (state_q == BUSY) & (cnt_q == CNT_W'(MEM_LATENCY)) & req_q.we & ce;

`ifndef SYNTHESIS
  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY must be >= 1");
  end

  a_one_ready : assert property (@(posedge clk) disable iff (!reset)
    !(if_req_ready && ls_req_ready));

  a_one_rsp : assert property (@(posedge clk) disable iff (!reset)
    (if_rsp_valid || ls_rsp_valid) |=> !(if_rsp_valid || ls_rsp_valid));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut (MEM_LATENCY=1) and dut3 (MEM_LATENCY=3) share all inputs;
// each phase checks the instance whose timing it exercises.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        ce;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        ls_req_valid;
  logic [31:0] ls_addr;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_wdata;
  logic [31:0] mem_rdata;

  logic        if_req_ready, if_rsp_valid, ls_req_ready, ls_rsp_valid, mem_we;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        b_if_req_ready, b_if_rsp_valid, b_ls_req_ready, b_ls_rsp_valid, b_mem_we;
  logic [31:0] b_if_rdata, b_ls_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  int n_chk  = 0;
  int n_fail = 0;

  mem_port_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .ce(ce),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_be(ls_be), .ls_wdata(ls_wdata),
    .ls_rsp_valid(ls_rsp_valid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .reset(reset), .ce(ce),
    .if_req_valid(if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rdata(b_if_rdata),
    .ls_req_valid(ls_req_valid), .ls_req_ready(b_ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_be(ls_be), .ls_wdata(ls_wdata),
    .ls_rsp_valid(b_ls_rsp_valid), .ls_rdata(b_ls_rdata),
    .mem_addr(b_mem_addr), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) nx();
  endtask

  initial begin
    logic got;

    reset = 1'b0; ce = 1'b1;
    if_req_valid = 1'b1; if_addr = 32'h0000_0004;
    ls_req_valid = 1'b1; ls_addr = 32'h0; ls_we = 1'b0; ls_be = 4'h0; ls_wdata = 32'h0;
    mem_rdata = 32'h0;

    // Reset state, with both requesters valid to prove no ready leaks out.
    smp();
    chk1 ("rst_if_ready",  if_req_ready, 1'b0);
    chk1 ("rst_ls_ready",  ls_req_ready, 1'b0);
    chk1 ("rst_if_rsp",    if_rsp_valid, 1'b0);
    chk1 ("rst_ls_rsp",    ls_rsp_valid, 1'b0);
    chk1 ("rst_mem_we",    mem_we,       1'b0);
    chk32("rst_mem_addr",  mem_addr,     32'h0);
    chk32("rst_mem_be",    {28'h0, mem_be}, 32'h0);
    chk32("rst_if_rdata",  if_rdata,     32'h0);
    nx();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    reset = 1'b1;
    idle_cycles(2);

    // Single fetch, latency 1.
    if_req_valid = 1'b1; if_addr = 32'h0000_0010; mem_rdata = 32'h0050_0093;
    smp();
    chk1 ("t1_if_ready", if_req_ready, 1'b1);
    chk1 ("t1_ls_ready", ls_req_ready, 1'b0);
    nx(); if_req_valid = 1'b0;
    smp();
    chk32("t1_mem_addr", mem_addr, 32'h0000_0010);
    chk32("t1_mem_be",   {28'h0, mem_be}, 32'h0000_000F);
    chk1 ("t1_mem_we",   mem_we, 1'b0);
    chk1 ("t1_rsp_early", if_rsp_valid, 1'b0);
    nx(); smp();
    chk1 ("t1_rsp",   if_rsp_valid, 1'b1);
    chk32("t1_rdata", if_rdata, 32'h0050_0093);
    nx(); smp();
    chk1 ("t1_rsp_once",  if_rsp_valid, 1'b0);
    chk32("t1_addr_hold", mem_addr, 32'h0000_0010);
    idle_cycles(4);

    // Store with an unaligned address and a single byte lane.
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0103; ls_we = 1'b1; ls_be = 4'b0001;
    ls_wdata = 32'h0000_00AB;
    smp();
    chk1 ("t2_ls_ready", ls_req_ready, 1'b1);
    nx(); ls_req_valid = 1'b0;
    smp();
    chk32("t2_mem_addr",  mem_addr, 32'h0000_0100);
    chk32("t2_mem_be",    {28'h0, mem_be}, 32'h0000_0001);
    chk32("t2_mem_wdata", mem_wdata, 32'h0000_00AB);
    chk1 ("t2_mem_we",    mem_we, 1'b1);
    nx(); smp();
    chk1 ("t2_mem_we_once", mem_we, 1'b0);
    chk1 ("t2_ls_rsp",      ls_rsp_valid, 1'b1);
    chk1 ("t2_if_rsp",      if_rsp_valid, 1'b0);
    chk32("t2_ls_rdata_hold", ls_rdata, 32'h0);
    nx(); smp();
    chk1 ("t2_ls_rsp_once", ls_rsp_valid, 1'b0);
    idle_cycles(4);

    // Load with latency 3 on dut3; dut completes the same load at latency 1.
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0200; ls_we = 1'b0; ls_be = 4'hF;
    mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk1("t3_ready", b_ls_req_ready, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      nx(); ls_req_valid = 1'b0;
      smp();
      chk1("t3_no_rsp_yet", b_ls_rsp_valid, 1'b0);
      if (k == 1) chk32("t3_mem_addr", b_mem_addr, 32'h0000_0200);
      if (k == 2) begin
        chk1 ("t3_l1_rsp",   ls_rsp_valid, 1'b1);
        chk32("t3_l1_rdata", ls_rdata, 32'hDEAD_BEEF);
      end
    end
    nx(); smp();
    chk1 ("t3_rsp",   b_ls_rsp_valid, 1'b1);
    chk32("t3_rdata", b_ls_rdata, 32'hDEAD_BEEF);
    nx(); smp();
    chk1 ("t3_rsp_once", b_ls_rsp_valid, 1'b0);
    idle_cycles(4);

    // ce low for 3 cycles: dut3 sits in BUSY, dut sits in RESP.
    if_req_valid = 1'b1; if_addr = 32'h0000_0040; mem_rdata = 32'h1234_5678;
    smp();
    chk1("t4_ready",   if_req_ready,   1'b1);
    chk1("t4_ready_b", b_if_req_ready, 1'b1);
    nx(); if_req_valid = 1'b0;
    smp();
    chk1("t4_b_rsp_c1", b_if_rsp_valid, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      nx(); ce = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      smp();
      chk1("t4_b_rsp_ce0",  b_if_rsp_valid, 1'b0);
      chk1("t4_rsp_ce0",    if_rsp_valid,   1'b0);
      chk1("t4_mem_we_ce0", b_mem_we,       1'b0);
    end
    nx(); ce = 1'b1; mem_rdata = 32'h1234_5678;
    smp();
    chk1 ("t4_pending_rsp", if_rsp_valid, 1'b1);
    chk32("t4_rdata",       if_rdata, 32'h1234_5678);
    chk1 ("t4_b_rsp_c5",    b_if_rsp_valid, 1'b0);
    nx(); smp();
    chk1 ("t4_b_rsp_c6",    b_if_rsp_valid, 1'b0);
    chk1 ("t4_rsp_once",    if_rsp_valid, 1'b0);
    nx(); smp();
    chk1 ("t4_b_rsp",   b_if_rsp_valid, 1'b1);
    chk32("t4_b_rdata", b_if_rdata, 32'h1234_5678);
    nx(); smp();
    chk1 ("t4_b_rsp_once", b_if_rsp_valid, 1'b0);
    idle_cycles(4);

    // Continuous contention on dut: LS x4, IF, LS x4, IF with the streak 0..4.
    if_req_valid = 1'b1; if_addr = 32'h0000_0080;
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0300; ls_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      got = 1'b0;
      for (int w = 0; w < 6; w++) begin
        if (i > 0 || w > 0) nx();
        smp();
        if (if_req_ready || ls_req_ready) begin
          got = 1'b1;
          break;
        end
      end
      chk1("t5_grant_seen", got, 1'b1);
      if (got) begin
        chk1 ("t5_if_grant", if_req_ready, (i % 5) == 4);
        chk1 ("t5_ls_grant", ls_req_ready, (i % 5) != 4);
        chk32("t5_streak",   32'(dut.u_prio.streak_q), 32'(i % 5));
      end
    end
    nx();
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    idle_cycles(8);

    // Reset in the first BUSY cycle of a store.
    ls_req_valid = 1'b1; ls_addr = 32'h0000_0300; ls_we = 1'b1; ls_be = 4'hF;
    ls_wdata = 32'h0000_0055;
    smp();
    chk1("t6_ls_ready", ls_req_ready, 1'b1);
    nx(); ls_req_valid = 1'b0;
    smp();
    chk1 ("t6_mem_we_before", mem_we, 1'b1);
    chk32("t6_mem_addr_before", mem_addr, 32'h0000_0300);
    #1 reset = 1'b0;
    #1;
    chk1 ("t6_mem_we_drop", mem_we, 1'b0);
    chk32("t6_mem_addr_rst", mem_addr, 32'h0);
    chk32("t6_mem_wdata_rst", mem_wdata, 32'h0);
    chk32("t6_mem_be_rst", {28'h0, mem_be}, 32'h0);
    chk32("t6_ls_rdata_rst", ls_rdata, 32'h0);
    chk32("t6_if_rdata_rst", if_rdata, 32'h0);
    nx(); smp();
    chk1("t6_no_rsp_rst", ls_rsp_valid, 1'b0);
    nx(); reset = 1'b1; ls_we = 1'b0;
    smp();
    chk1("t6_no_rsp_after", ls_rsp_valid, 1'b0);
    nx();
    if_req_valid = 1'b1; if_addr = 32'h0000_0080; mem_rdata = 32'hCAFE_F00D;
    smp();
    chk1("t6_if_ready", if_req_ready, 1'b1);
    nx(); if_req_valid = 1'b0;
    smp();
    chk32("t6_fetch_addr", mem_addr, 32'h0000_0080);
    nx(); smp();
    chk1 ("t6_fetch_rsp",   if_rsp_valid, 1'b1);
    chk32("t6_fetch_rdata", if_rdata, 32'hCAFE_F00D);
    chk1 ("t6_ls_rsp_none", ls_rsp_valid, 1'b0);
    idle_cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog expired");
  end

endmodule
